// File: rtl/pp_accumulator_pkg.sv
// Shared MAC constants, state encoding and small helpers for the partial-product accumulator.
package pp_accumulator_pkg;

   localparam int unsigned PP_W      = 4;
   localparam int unsigned EXP_W     = 6;
   localparam int unsigned ACC_W     = 46;
   localparam int unsigned MAX_EXP   = 38;
   localparam int unsigned MAX_TERMS = 16;
   localparam int unsigned CNT_W     = 5;

   typedef logic [1:0]       state_t;
   typedef logic [ACC_W-1:0] acc_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StAcc  = 2'd1;
   localparam state_t StDone = 2'd2;

   // Term counter that sticks at MAX_TERMS once reached.
   function automatic cnt_t count_sat(input cnt_t c);
      return (c >= CNT_W'(MAX_TERMS)) ? c : c + cnt_t'(1);
   endfunction

endpackage

// File: rtl/pp_align.sv
// Aligns one denormalised partial product onto the fixed-point accumulator grid.
module pp_align
   import pp_accumulator_pkg::*;
(
   input  logic [PP_W-1:0]  denorm_pp_i,
   input  logic [EXP_W-1:0] exp_i,
   output logic [ACC_W-1:0] term_o,
   output logic             err_o
);

   logic [ACC_W-1:0] mag;

   // Zero check, shift, conditional negate; an out-of-range exp is flagged and adds nothing.
   always_comb begin
      err_o = (exp_i > EXP_W'(MAX_EXP));
      mag   = '0;
      if (denorm_pp_i[2] && !err_o) begin
         mag = ACC_W'(denorm_pp_i[2:0]) << exp_i;
      end
      term_o = denorm_pp_i[3] ? (ACC_W'(0) - mag) : mag;
   end

endmodule

// File: rtl/pp_accumulator.sv
// Accumulates aligned partial-product terms per dot-product group and holds the group result.
module pp_accumulator
   import pp_accumulator_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [PP_W-1:0]  denorm_pp,
   input  logic [EXP_W-1:0] exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             out_err
);

   state_t state_q, state_d;
   acc_t   acc_q, acc_d;
   cnt_t   count_q, count_d;
   logic   ovf_q, ovf_d;
   logic   err_q, err_d;

   acc_t   term;
   logic   term_err;
   logic   accept;

   pp_align u_align (
      .denorm_pp_i (denorm_pp),
      .exp_i       (exp),
      .term_o      (term),
      .err_o       (term_err)
   );

   assign in_ready = (state_q != StDone);
   assign accept   = in_valid && in_ready;

   // Next-state: add one term per accepted cycle, close on in_last, clear on result handoff.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle, StAcc: begin
            if (accept) begin
               acc_d   = acc_q + term;
               count_d = count_sat(count_q);
               // A term arriving when the count already sits at the limit is the 17th or later.
               ovf_d   = ovf_q | (count_q == CNT_W'(MAX_TERMS));
               err_d   = err_q | term_err;
               state_d = in_last ? StDone : StAcc;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
         end
      endcase
   end

   // State registers; reset discards any open group.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   // Result outputs are forced to zero unless a finished group is being presented.
   always_comb begin
      out_valid = (state_q == StDone);
      out_sum   = out_valid ? acc_q   : '0;
      out_count = out_valid ? count_q : '0;
      out_ovf   = out_valid & ovf_q;
      out_err   = out_valid & err_q;
   end

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed self-checking bench for pp_accumulator.
module tb_pp_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [3:0]  denorm_pp;
   logic [5:0]  exp;
   logic        out_valid;
   logic        out_ready;
   logic [45:0] out_sum;
   logic [4:0]  out_count;
   logic        out_ovf;
   logic        out_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pp_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .denorm_pp (denorm_pp),
      .exp       (exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf),
      .out_err   (out_err)
   );

   typedef struct {
      logic [3:0]  pp;
      logic [5:0]  e;
      logic [45:0] sum;
      logic        err;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] pp, input logic [5:0] e, input logic last);
      in_valid  = 1'b1;
      denorm_pp = pp;
      exp       = e;
      in_last   = last;
      step();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      denorm_pp = 4'b0000;
      exp       = 6'd0;
   endtask

   task automatic check_result(input string name, input logic [45:0] sum, input logic [4:0] cnt,
                               input logic ovf, input logic err);
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_sum"},   64'(out_sum),   64'(sum));
      chk({name, "_count"}, 64'(out_count), 64'(cnt));
      chk({name, "_ovf"},   64'(out_ovf),   64'(ovf));
      chk({name, "_err"},   64'(out_err),   64'(err));
      chk({name, "_inrdy"}, 64'(in_ready),  64'd0);
   endtask

   task automatic check_idle(input string name);
      chk({name, "_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_inrdy"}, 64'(in_ready),  64'd1);
      chk({name, "_sum"},   64'(out_sum),   64'd0);
      chk({name, "_count"}, 64'(out_count), 64'd0);
      chk({name, "_flags"}, 64'({out_ovf, out_err}), 64'd0);
   endtask

   task automatic release_result(input string name);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_idle(name);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      denorm_pp = 4'b0000;
      exp       = 6'd0;
      out_ready = 1'b0;

      // Single-term groups: {pp, exp, expected sum, expected err}.
      vecs[0] = '{4'b0111, 6'd0,  46'd7,                 1'b0};
      vecs[1] = '{4'b0000, 6'd38, 46'd0,                 1'b0};
      vecs[2] = '{4'b0100, 6'd40, 46'd0,                 1'b1};
      vecs[3] = '{4'b1111, 6'd2,  46'd0 - 46'd28,        1'b0};
      vecs[4] = '{4'b0011, 6'd5,  46'd0,                 1'b0};
      vecs[5] = '{4'b0111, 6'd38, 46'd7 << 38,           1'b0};
      vecs[6] = '{4'b1100, 6'd38, 46'd0 - (46'd4 << 38), 1'b0};
      vecs[7] = '{4'b1000, 6'd63, 46'd0,                 1'b1};

      step();
      step();
      rst = 1'b0;
      check_idle("reset");

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].pp, vecs[i].e, 1'b1);
         check_result($sformatf("vec%0d", i), vecs[i].sum, 5'd1, 1'b0, vecs[i].err);
         release_result($sformatf("vec%0d_rel", i));
      end

      // Two terms with an idle gap: 32 - 10 = 22.
      send(4'b0100, 6'd3, 1'b0);
      chk("grp2_open_valid", 64'(out_valid), 64'd0);
      chk("grp2_open_sum",   64'(out_sum),   64'd0);
      chk("grp2_open_inrdy", 64'(in_ready),  64'd1);
      step();
      send(4'b1101, 6'd1, 1'b1);
      check_result("grp2", 46'd22, 5'd2, 1'b0, 1'b0);
      release_result("grp2_rel");

      // Exactly 16 terms: no overflow.
      for (int i = 0; i < 15; i++) send(4'b0100, 6'd0, 1'b0);
      send(4'b0100, 6'd0, 1'b1);
      check_result("grp16", 46'd64, 5'd16, 1'b0, 1'b0);
      release_result("grp16_rel");

      // 17 terms: count saturates, overflow sticky.
      for (int i = 0; i < 16; i++) send(4'b0100, 6'd0, 1'b0);
      send(4'b0100, 6'd0, 1'b1);
      check_result("grp17", 46'd68, 5'd16, 1'b1, 1'b0);
      release_result("grp17_rel");

      // Back-pressure: result held, new terms refused.
      send(4'b0111, 6'd1, 1'b1);
      in_valid  = 1'b1;
      in_last   = 1'b1;
      denorm_pp = 4'b0111;
      exp       = 6'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_result($sformatf("stall%0d", i), 46'd14, 5'd1, 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      chk("stall_handoff_inrdy", 64'(in_ready), 64'd0);
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      check_idle("stall_rel");
      step();
      check_idle("stall_after");

      // Reset mid-group, coinciding with a last term: group discarded.
      send(4'b0111, 6'd0, 1'b0);
      send(4'b0111, 6'd0, 1'b0);
      send(4'b0111, 6'd0, 1'b0);
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_last   = 1'b1;
      denorm_pp = 4'b0111;
      step();
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      check_idle("rst_mid");
      step();
      check_idle("rst_mid_after");
      send(4'b0101, 6'd2, 1'b1);
      check_result("post_rst", 46'd20, 5'd1, 1'b0, 1'b0);
      release_result("post_rst_rel");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pp_accumulator.md
PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  in  1  partial-product term present.
REQ-004 SHALL have ports: in_ready  out  1  block accepts a term this cycle.
REQ-005 SHALL have ports: in_last  in  1  term is the final one of its dot-product group.
REQ-006 SHALL have ports: denorm_pp  in  4  {sign, leading one, mant[1:0]}; 4'b0000 or 4'b1000 means zero.
REQ-007 SHALL have ports: exp  in  6  unbiased shift amount, legal range 0..38.
REQ-008 SHALL have ports: out_valid  out  1  group result held.
REQ-009 SHALL have ports: out_ready  in  1  consumer takes the result.
REQ-010 SHALL have ports: out_sum  out  46  two's-complement fixed-point group sum, LSB weight 2^-2.
REQ-011 SHALL have ports: out_count  out  5  number of terms accepted in the group, 1..16.
REQ-012 SHALL have ports: out_ovf  out  1  group exceeded 16 terms.
REQ-013 SHALL have ports: out_err  out  1  group contained an illegal exp (>38).

Function
REQ-014 SHALL transfer a term only on in_valid && in_ready.
REQ-015 SHALL align each term as magnitude {denorm_pp[2:0]} << exp, zero-extended to 46 bits, negated when denorm_pp[3]=1.
REQ-016 SHALL make a term whose denorm_pp[2]=0 contribute 0, whatever its exp.
REQ-017 SHALL make a term whose exp>38 contribute 0 and set the group's sticky err flag.
REQ-018 SHALL accumulate modulo 2^46; one accepted term is added per cycle with no bubbles.
REQ-019 SHALL provide states IDLE (acc=0, count=0), ACC (group open) and DONE (result held).
REQ-020 SHALL transition IDLE->ACC on an accepted term without in_last, and IDLE->DONE or ACC->DONE on an accepted term with in_last; ACC holds while in_valid is low.
REQ-021 SHALL assert out_valid in the cycle after the in_last term is accepted (latency 1), with out_sum including that term.
REQ-022 SHALL hold in_ready=1 in IDLE and ACC, and in_ready=0 in DONE, including the cycle in which out_ready is high.
REQ-023 SHALL keep out_sum, out_count, out_ovf and out_err stable while out_valid && !out_ready.
REQ-024 SHALL, on out_valid && out_ready, go to IDLE, clearing the accumulator, count and flags.
REQ-025 SHALL, on acceptance of a 17th or later term, keep accumulating, saturate out_count at 16 and set the sticky ovf flag.
REQ-026 SHALL keep out_sum, out_count, out_ovf and out_err at 0 whenever out_valid=0.

Reset
REQ-027 SHALL, with rst high at a clk edge, go to IDLE with in_ready=1, out_valid=0 and all other outputs 0.
REQ-028 SHALL make rst take priority over any simultaneous handshake; a group in progress is discarded, not emitted.

Structure
REQ-029 SHALL take PP_W=4, EXP_W=6, ACC_W=46, MAX_EXP=38, MAX_TERMS=16 and the state enumeration from the shared MAC package.
REQ-030 SHALL place the alignment (zero check, shift, conditional negate, err detect) in one combinational sub-module, pp_align.

Verification
REQ-031 SHALL check: single term pp=4'b0111, exp=0, last -> next cycle out_valid=1, out_sum=7, out_count=1.
REQ-032 SHALL check: terms (4'b0100,exp=3), (4'b1101,exp=1), last -> out_sum=32-10=22, out_count=2.
REQ-033 SHALL check: term pp=4'b0000, exp=38, last -> out_sum=0, out_err=0; term pp=4'b0100, exp=40, last -> out_sum=0, out_err=1.
REQ-034 SHALL check: 17 terms of (4'b0100,exp=0) -> out_sum=68, out_count=16, out_ovf=1.
REQ-035 SHALL check: out_ready held low 5 cycles -> outputs stable and in_ready=0 throughout; out_ready high -> next cycle IDLE, in_ready=1, out_valid=0.
REQ-036 SHALL check: rst asserted mid-group after 3 terms, then a new group (4'b0101,exp=2), last -> out_sum=20, out_count=1.
